// File: rtl/rca_4bit.sv
// Registered 4-bit ripple-carry adder: one clock latency, one result per clock.
// No backpressure; outputs hold their last result whenever in_valid is low.
module rca_fa (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (a & ci) | (b & ci);
endmodule

module rca_4bit (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout,
  output logic       ovf,
  output logic       out_valid
);
  logic [4:0] c;
  logic [3:0] s;
  logic       ovf_comb;

  assign c[0] = cin;

  // Explicit cell chain keeps the carry path at four deterministic stages.
  for (genvar i = 0; i < 4; i++) begin : g_fa
    rca_fa u_fa (
      .a  (a[i]),
      .b  (b[i]),
      .ci (c[i]),
      .s  (s[i]),
      .co (c[i+1])
    );
  end

  assign ovf_comb = c[3] ^ c[4];

  // Data registers load only on valid, so X on idle inputs never reaches them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum       <= 4'd0;
      cout      <= 1'b0;
      ovf       <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        sum  <= s;
        cout <= c[4];
        ovf  <= ovf_comb;
      end
    end
  end
endmodule

// File: tb/tb_rca_4bit.sv
// Directed and exhaustive check of rca_4bit with immediate assertions.
module tb_rca_4bit;
  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic [3:0] a;
  logic [3:0] b;
  logic       cin;
  logic [3:0] sum;
  logic       cout;
  logic       ovf;
  logic       out_valid;

  int checks;
  int errors;

  rca_4bit dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf),
    .out_valid (out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [3:0] es, input logic ec,
                         input logic eo, input logic ev);
    chk({tag, ".sum"}, sum, es);
    chk({tag, ".cout"}, {3'b0, cout}, {3'b0, ec});
    chk({tag, ".ovf"}, {3'b0, ovf}, {3'b0, eo});
    chk({tag, ".out_valid"}, {3'b0, out_valid}, {3'b0, ev});
  endtask

  // Drive one valid vector, clock it, and check against an arithmetic model.
  task automatic vec(input string tag, input logic [3:0] va, input logic [3:0] vb,
                     input logic vc);
    int unsigned u;
    int sa, sb, ss;
    logic [4:0] r;
    in_valid = 1'b1;
    a = va;
    b = vb;
    cin = vc;
    @(posedge clk);
    #1;
    u = int'(va) + int'(vb) + int'(vc);
    r = u[4:0];
    sa = va[3] ? int'(va) - 16 : int'(va);
    sb = vb[3] ? int'(vb) - 16 : int'(vb);
    ss = sa + sb + int'(vc);
    chk_all(tag, r[3:0], r[4], (ss > 7) || (ss < -8), 1'b1);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n = 1'b0;
    in_valid = 1'b1;
    a = 4'($urandom);
    b = 4'($urandom);
    cin = 1'($urandom);

    // Reset held with valid inputs: outputs clear and stay clear across edges.
    #2;
    chk_all("reset_t0", 4'd0, 1'b0, 1'b0, 1'b0);
    repeat (3) begin
      @(posedge clk);
      #1;
      a = 4'($urandom);
      b = 4'($urandom);
      chk_all("reset_hold", 4'd0, 1'b0, 1'b0, 1'b0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    in_valid = 1'b0;
    @(posedge clk);
    #1;

    // Hand-computed directed vectors.
    in_valid = 1'b1; a = 4'd4; b = 4'd5; cin = 1'b0;
    @(posedge clk); #1; chk_all("v4p5", 4'd9, 1'b0, 1'b1, 1'b1);
    a = 4'd9; b = 4'd14; cin = 1'b1;
    @(posedge clk); #1; chk_all("v9p14c", 4'd8, 1'b1, 1'b0, 1'b1);
    a = 4'd5; b = 4'd8; cin = 1'b0;
    @(posedge clk); #1; chk_all("v5p8", 4'd13, 1'b0, 1'b0, 1'b1);
    a = 4'd8; b = 4'd7; cin = 1'b1;
    @(posedge clk); #1; chk_all("v8p7c", 4'd0, 1'b1, 1'b0, 1'b1);
    a = 4'd15; b = 4'd0; cin = 1'b1;
    @(posedge clk); #1; chk_all("v15p0c", 4'd0, 1'b1, 1'b0, 1'b1);
    a = 4'd15; b = 4'd15; cin = 1'b1;
    @(posedge clk); #1; chk_all("v15p15c", 4'd15, 1'b1, 1'b0, 1'b1);
    a = 4'd7; b = 4'd0; cin = 1'b1;
    @(posedge clk); #1; chk_all("v7p0c", 4'd8, 1'b0, 1'b1, 1'b1);

    // Hold: idle cycles with changing and unknown inputs leave the result intact.
    a = 4'd3; b = 4'd2; cin = 1'b0;
    @(posedge clk); #1; chk_all("hold_load", 4'd5, 1'b0, 1'b0, 1'b1);
    in_valid = 1'b0; a = 4'd15; b = 4'd15;
    repeat (3) begin
      @(posedge clk); #1; chk_all("hold_idle", 4'd5, 1'b0, 1'b0, 1'b0);
    end
    a = 4'bxxxx; b = 4'bxxxx; cin = 1'bx;
    @(posedge clk); #1; chk_all("hold_x", 4'd5, 1'b0, 1'b0, 1'b0);

    // Exhaustive, valid every cycle.
    for (int i = 0; i < 512; i++) begin
      vec("exh", 4'(i >> 5), 4'(i >> 1), 1'(i));
    end
    in_valid = 1'b0;
    @(posedge clk); #1; chk_all("exh_tail", 4'd15, 1'b1, 1'b0, 1'b0);

    // Reset mid-stream: clears without a clock, next result reflects only its inputs.
    vec("mid_pre", 4'd6, 4'd6, 1'b0);
    in_valid = 1'b1; a = 4'd12; b = 4'd9; cin = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    chk_all("mid_rst", 4'd0, 1'b0, 1'b0, 1'b0);
    @(posedge clk); #1; chk_all("mid_rst_edge", 4'd0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    vec("mid_post", 4'd2, 4'd3, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
